mini_ctrl: RTL and testbench

//  Multi-cycle sequencer for the mini CPU. Owns PC and instruction register, fetches from the

---
 rtl/mini_pkg.sv | 65 ++++++
 rtl/mini_decode.sv | 65 ++++++
 rtl/mini_ctrl.sv | 167 ++++++++++++++++
 tb/tb_mini_ctrl.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mini_pkg.sv
// -----------------------------------------------------------------------------
// mini_pkg
// Shared definitions for the mini CPU sequencer, its datapath and the bench:
// opcodes, FSM state encoding, write-data mux and ALU codes, and the bit
// positions of the fields in the 16-bit instruction word
//    {op[15:12], rd[11:10], rs[9:8], imm[7:0]}.
// -----------------------------------------------------------------------------
package mini_pkg;

   localparam int INSTR_W = 16;

   localparam int OP_HI  = 15;
   localparam int OP_LO  = 12;
   localparam int RD_HI  = 11;
   localparam int RD_LO  = 10;
   localparam int RS_HI  = 9;
   localparam int RS_LO  = 8;
   localparam int IMM_HI = 7;
   localparam int IMM_LO = 0;

   localparam logic [3:0] OP_NOP  = 4'h0;
   localparam logic [3:0] OP_LDI  = 4'h1;
   localparam logic [3:0] OP_ADD  = 4'h2;
   localparam logic [3:0] OP_SUB  = 4'h3;
   localparam logic [3:0] OP_XOR  = 4'h4;
   localparam logic [3:0] OP_LD   = 4'h5;
   localparam logic [3:0] OP_ST   = 4'h6;
   localparam logic [3:0] OP_JMP  = 4'h7;
   localparam logic [3:0] OP_HALT = 4'hF;

   localparam logic [1:0] RF_WSEL_ALU  = 2'd0;
   localparam logic [1:0] RF_WSEL_IMM  = 2'd1;
   localparam logic [1:0] RF_WSEL_DMEM = 2'd2;

   localparam logic [1:0] ALU_ADD  = 2'd0;
   localparam logic [1:0] ALU_SUB  = 2'd1;
   localparam logic [1:0] ALU_XOR  = 2'd2;
   localparam logic [1:0] ALU_PASS = 2'd3;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_FETCH  = 3'd1,
      ST_DECODE = 3'd2,
      ST_EXEC   = 3'd3,
      ST_MEM    = 3'd4,
      ST_HALT   = 3'd5
   } state_t;

   function automatic logic [3:0] ir_op(input logic [INSTR_W-1:0] ir);
      return ir[OP_HI:OP_LO];
   endfunction

   function automatic logic [1:0] ir_rd(input logic [INSTR_W-1:0] ir);
      return ir[RD_HI:RD_LO];
   endfunction

   function automatic logic [1:0] ir_rs(input logic [INSTR_W-1:0] ir);
      return ir[RS_HI:RS_LO];
   endfunction

   function automatic logic [7:0] ir_imm(input logic [INSTR_W-1:0] ir);
      return ir[IMM_HI:IMM_LO];
   endfunction

endpackage

// File: rtl/mini_decode.sv
// -----------------------------------------------------------------------------
// mini_decode
// Purely combinational opcode decoder for the mini CPU sequencer.
// Ports:
//    ir       in   16  instruction register
//    is_ldi   out  1   load-immediate
//    is_alu   out  1   ADD / SUB / XOR register-register op
//    is_ld    out  1   load from data memory
//    is_st    out  1   store to data memory
//    is_jmp   out  1   absolute jump to imm
//    is_halt  out  1   HALT
//    is_ill   out  1   opcode 8..E
//    alu_op   out  2   ALU function for is_alu, ALU_ADD otherwise
// -----------------------------------------------------------------------------
module mini_decode
   import mini_pkg::*;
(
   input  logic [INSTR_W-1:0] ir,
   output logic               is_ldi,
   output logic               is_alu,
   output logic               is_ld,
   output logic               is_st,
   output logic               is_jmp,
   output logic               is_halt,
   output logic               is_ill,
   output logic [1:0]         alu_op
);

   logic [3:0] op;

   assign op = ir_op(ir);

   always_comb begin
      is_ldi  = 1'b0;
      is_alu  = 1'b0;
      is_ld   = 1'b0;
      is_st   = 1'b0;
      is_jmp  = 1'b0;
      is_halt = 1'b0;
      is_ill  = 1'b0;
      alu_op  = ALU_ADD;
      case (op)
         OP_NOP:  ;
         OP_LDI:  is_ldi = 1'b1;
         OP_ADD: begin
            is_alu = 1'b1;
            alu_op = ALU_ADD;
         end
         OP_SUB: begin
            is_alu = 1'b1;
            alu_op = ALU_SUB;
         end
         OP_XOR: begin
            is_alu = 1'b1;
            alu_op = ALU_XOR;
         end
         OP_LD:   is_ld   = 1'b1;
         OP_ST:   is_st   = 1'b1;
         OP_JMP:  is_jmp  = 1'b1;
         OP_HALT: is_halt = 1'b1;
         default: is_ill  = 1'b1;
      endcase
   end

endmodule

// File: rtl/mini_ctrl.sv
// -----------------------------------------------------------------------------
// mini_ctrl
// Multi-cycle sequencer for the mini CPU. Owns PC and IR, fetches from a
// combinational instruction ROM, and drives register-file, ALU and data-memory
// control for an external datapath.
// Parameters:
//    PC_W      PC / imem address width and dmem address width
//    CNT_W     retired-instruction counter width (saturating)
//    HALT_ILL  1: illegal opcode halts; 0: illegal opcode behaves as NOP
// Ports:
//    clk, rst_n          clock, async active-low reset
//    start               in IDLE, begins fetching at pc=0
//    imem_addr/imem_data instruction ROM address (= pc) / word
//    rf_ra, rf_rb        read selects (rd, rs)
//    rf_we, rf_wa        write strobe / address (rd)
//    rf_wsel             write data mux (ALU / IMM / DMEM)
//    alu_op              ALU function
//    imm                 IR immediate field
//    dmem_addr           data memory address (= imm)
//    dmem_we, dmem_re    store strobe / load request
//    dmem_rvalid         load data valid
//    busy, halted        status
//    illegal             sticky illegal-opcode flag
//    retired             saturating retired-instruction count
//
// state  | meaning
// -------+-------------------------------------------------------------
// IDLE   | waiting for start
// FETCH  | IR <= imem_data, pc <= pc+1
// DECODE | rd/rs presented on the read selects for operand read
// EXEC   | write/store/load strobe, jump, or halt decision
// MEM    | waiting for load data; writes rd when dmem_rvalid
// HALT   | terminal until reset
// -----------------------------------------------------------------------------
module mini_ctrl
   import mini_pkg::*;
#(
   parameter int PC_W     = 8,
   parameter int CNT_W    = 16,
   parameter bit HALT_ILL = 1'b0
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               start,
   output logic [PC_W-1:0]    imem_addr,
   input  logic [INSTR_W-1:0] imem_data,
   output logic [1:0]         rf_ra,
   output logic [1:0]         rf_rb,
   output logic               rf_we,
   output logic [1:0]         rf_wa,
   output logic [1:0]         rf_wsel,
   output logic [1:0]         alu_op,
   output logic [7:0]         imm,
   output logic [PC_W-1:0]    dmem_addr,
   output logic               dmem_we,
   output logic               dmem_re,
   input  logic               dmem_rvalid,
   output logic               busy,
   output logic               halted,
   output logic               illegal,
   output logic [CNT_W-1:0]   retired
);

   state_t             state;
   logic [PC_W-1:0]    pc;
   logic [INSTR_W-1:0] ir;

   logic       d_ldi;
   logic       d_alu;
   logic       d_ld;
   logic       d_st;
   logic       d_jmp;
   logic       d_halt;
   logic       d_ill;
   logic [1:0] d_alu_op;

   logic in_exec;
   logic in_mem;
   logic retire;
   logic go_halt;

   mini_decode u_decode (
      .ir      (ir),
      .is_ldi  (d_ldi),
      .is_alu  (d_alu),
      .is_ld   (d_ld),
      .is_st   (d_st),
      .is_jmp  (d_jmp),
      .is_halt (d_halt),
      .is_ill  (d_ill),
      .alu_op  (d_alu_op)
   );

   assign in_exec = (state == ST_EXEC);
   assign in_mem  = (state == ST_MEM);

   // An instruction retires when it leaves EXEC for FETCH/HALT, or leaves MEM.
   assign retire  = (in_exec && !d_ld) || (in_mem && dmem_rvalid);
   assign go_halt = d_halt || (d_ill && HALT_ILL);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= ST_IDLE;
         pc      <= '0;
         ir      <= '0;
         retired <= '0;
         illegal <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (start) state <= ST_FETCH;
            end
            ST_FETCH: begin
               ir    <= imem_data;
               pc    <= pc + 1'b1;
               state <= ST_DECODE;
            end
            ST_DECODE: begin
               state <= ST_EXEC;
            end
            ST_EXEC: begin
               if (d_ill) illegal <= 1'b1;
               if (d_jmp) pc <= PC_W'(ir_imm(ir));
               if (d_ld)         state <= ST_MEM;
               else if (go_halt) state <= ST_HALT;
               else              state <= ST_FETCH;
            end
            ST_MEM: begin
               if (dmem_rvalid) state <= ST_FETCH;
            end
            ST_HALT: begin
               state <= ST_HALT;
            end
            default: begin
               state <= ST_IDLE;
            end
         endcase

         if (retire && (retired != {CNT_W{1'b1}})) retired <= retired + 1'b1;
      end
   end

   // Control outputs decode from the registered state and IR, so a reset
   // drops every strobe in the same instant the state returns to IDLE.
   assign imem_addr = pc;
   assign rf_ra     = ir_rd(ir);
   assign rf_rb     = ir_rs(ir);
   assign rf_wa     = ir_rd(ir);
   assign imm       = ir_imm(ir);
   assign dmem_addr = PC_W'(ir_imm(ir));

   assign rf_we   = (in_exec && (d_ldi || d_alu)) || (in_mem && dmem_rvalid);
   assign dmem_we = in_exec && d_st;
   assign dmem_re = in_exec && d_ld;

   always_comb begin
      rf_wsel = RF_WSEL_ALU;
      if (in_mem)                rf_wsel = RF_WSEL_DMEM;
      else if (in_exec && d_ldi) rf_wsel = RF_WSEL_IMM;
   end

   assign alu_op = d_alu ? d_alu_op : ALU_ADD;

   assign busy   = (state != ST_IDLE) && (state != ST_HALT);
   assign halted = (state == ST_HALT);

endmodule

// File: tb/tb_mini_ctrl.sv
module tb_mini_ctrl;
   import mini_pkg::*;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start = 1'b0;
   logic        dmem_rvalid = 1'b0;

   logic [15:0] rom   [0:255];
   logic [15:0] rom_h [0:255];

   logic [7:0]  imem_addr, dmem_addr, imm;
   logic [15:0] imem_data;
   logic [1:0]  rf_ra, rf_rb, rf_wa, rf_wsel, alu_op;
   logic        rf_we, dmem_we, dmem_re, busy, halted, illegal;
   logic [15:0] retired;

   logic [7:0]  h_imem_addr, h_dmem_addr, h_imm;
   logic [15:0] h_imem_data;
   logic [1:0]  h_rf_ra, h_rf_rb, h_rf_wa, h_rf_wsel, h_alu_op;
   logic        h_rf_we, h_dmem_we, h_dmem_re, h_busy, h_halted, h_illegal;
   logic [15:0] h_retired;

   int n_pass = 0;
   int n_fail = 0;
   int n_total = 0;

   always #5 clk = ~clk;

   assign imem_data   = rom[imem_addr];
   assign h_imem_data = rom_h[h_imem_addr];

   mini_ctrl #(.PC_W(8), .CNT_W(16), .HALT_ILL(1'b0)) dut (
      .clk(clk), .rst_n(rst_n), .start(start),
      .imem_addr(imem_addr), .imem_data(imem_data),
      .rf_ra(rf_ra), .rf_rb(rf_rb), .rf_we(rf_we), .rf_wa(rf_wa),
      .rf_wsel(rf_wsel), .alu_op(alu_op), .imm(imm),
      .dmem_addr(dmem_addr), .dmem_we(dmem_we), .dmem_re(dmem_re),
      .dmem_rvalid(dmem_rvalid), .busy(busy), .halted(halted),
      .illegal(illegal), .retired(retired)
   );

   mini_ctrl #(.PC_W(8), .CNT_W(16), .HALT_ILL(1'b1)) dut_h (
      .clk(clk), .rst_n(rst_n), .start(start),
      .imem_addr(h_imem_addr), .imem_data(h_imem_data),
      .rf_ra(h_rf_ra), .rf_rb(h_rf_rb), .rf_we(h_rf_we), .rf_wa(h_rf_wa),
      .rf_wsel(h_rf_wsel), .alu_op(h_alu_op), .imm(h_imm),
      .dmem_addr(h_dmem_addr), .dmem_we(h_dmem_we), .dmem_re(h_dmem_re),
      .dmem_rvalid(dmem_rvalid), .busy(h_busy), .halted(h_halted),
      .illegal(h_illegal), .retired(h_retired)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Advance one cycle; drive rvalid just after the edge, sample 2 time units later.
   task automatic step(input logic rv);
      @(posedge clk);
      #1;
      dmem_rvalid = rv;
      #1;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      start = 1'b0;
      dmem_rvalid = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      #1;
   endtask

   task automatic clear_rom();
      for (int i = 0; i < 256; i++) rom[i] = 16'h0000;
   endtask

   task automatic chk_reset_vals(input string tag);
      chk({tag, ".busy"},    32'(busy), 0);
      chk({tag, ".halted"},  32'(halted), 0);
      chk({tag, ".illegal"}, 32'(illegal), 0);
      chk({tag, ".retired"}, 32'(retired), 0);
      chk({tag, ".pc"},      32'(imem_addr), 0);
      chk({tag, ".rf_we"},   32'(rf_we), 0);
      chk({tag, ".dmem_we"}, 32'(dmem_we), 0);
      chk({tag, ".dmem_re"}, 32'(dmem_re), 0);
      chk({tag, ".rf_wsel"}, 32'(rf_wsel), 0);
      chk({tag, ".alu_op"},  32'(alu_op), 0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: observed timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int exp_we, exp_dwe, exp_dre;

      for (int i = 0; i < 256; i++) rom_h[i] = 16'h0000;
      rom_h[0] = 16'h9000;

      // ---------------- demo program ----------------
      clear_rom();
      rom[0] = 16'h1005;  // LDI R0,5
      rom[1] = 16'h1403;  // LDI R1,3
      rom[2] = 16'h2100;  // ADD R0,R1
      rom[3] = 16'h6010;  // ST  R0 -> 0x10
      rom[4] = 16'h5810;  // LD  R2 <- 0x10
      rom[5] = 16'h4900;  // XOR R2,R1
      rom[6] = 16'h7002;  // JMP 2

      do_reset();
      chk_reset_vals("rst");
      start = 1'b1;
      for (int c = 1; c <= 23; c++) begin
         step(c == 16);
         if (c == 2) start = 1'b0;
         exp_we  = (c == 3 || c == 6 || c == 9 || c == 16 || c == 19) ? 1 : 0;
         exp_dwe = (c == 12) ? 1 : 0;
         exp_dre = (c == 15) ? 1 : 0;
         chk("demo.rf_we", 32'(rf_we), exp_we);
         chk("demo.dmem_we", 32'(dmem_we), exp_dwe);
         chk("demo.dmem_re", 32'(dmem_re), exp_dre);
         chk("demo.busy", 32'(busy), 1);
         case (c)
            1:  chk("demo.fetch0", 32'(imem_addr), 0);
            3: begin
               chk("demo.ldi0.imm", 32'(imm), 32'h05);
               chk("demo.ldi0.wsel", 32'(rf_wsel), 1);
               chk("demo.ldi0.wa", 32'(rf_wa), 0);
            end
            4:  chk("demo.fetch1", 32'(imem_addr), 1);
            6: begin
               chk("demo.ldi1.imm", 32'(imm), 32'h03);
               chk("demo.ldi1.wa", 32'(rf_wa), 1);
            end
            7:  chk("demo.fetch2", 32'(imem_addr), 2);
            8: begin
               chk("demo.add.ra", 32'(rf_ra), 0);
               chk("demo.add.rb", 32'(rf_rb), 1);
            end
            9: begin
               chk("demo.add.wsel", 32'(rf_wsel), 0);
               chk("demo.add.op", 32'(alu_op), 0);
            end
            10: chk("demo.fetch3", 32'(imem_addr), 3);
            12: chk("demo.st.addr", 32'(dmem_addr), 32'h10);
            13: chk("demo.fetch4", 32'(imem_addr), 4);
            15: chk("demo.ld.addr", 32'(dmem_addr), 32'h10);
            16: begin
               chk("demo.ld.wsel", 32'(rf_wsel), 2);
               chk("demo.ld.wa", 32'(rf_wa), 2);
            end
            17: chk("demo.fetch5", 32'(imem_addr), 5);
            19: begin
               chk("demo.xor.op", 32'(alu_op), 2);
               chk("demo.xor.wa", 32'(rf_wa), 2);
            end
            20: chk("demo.fetch6", 32'(imem_addr), 6);
            22: chk("demo.jmp.retired", 32'(retired), 6);
            23: begin
               chk("demo.after_jmp.retired", 32'(retired), 7);
               chk("demo.after_jmp.fetch", 32'(imem_addr), 2);
            end
            default: ;
         endcase
      end

      // ---------------- LD with slow rvalid, then HALT ----------------
      clear_rom();
      rom[0] = 16'h5C20;  // LD R3 <- 0x20
      rom[1] = 16'hF000;  // HALT
      do_reset();
      start = 1'b1;
      step(1'b0);
      step(1'b0);
      step(1'b0);
      chk("ld.re", 32'(dmem_re), 1);
      chk("ld.addr", 32'(dmem_addr), 32'h20);
      start = 1'b0;
      for (int k = 0; k < 5; k++) begin
         step(1'b0);
         chk("ldw.busy", 32'(busy), 1);
         chk("ldw.rf_we", 32'(rf_we), 0);
         chk("ldw.dmem_re", 32'(dmem_re), 0);
         chk("ldw.dmem_we", 32'(dmem_we), 0);
      end
      step(1'b1);
      chk("ldw.rv.rf_we", 32'(rf_we), 1);
      chk("ldw.rv.wsel", 32'(rf_wsel), 2);
      chk("ldw.rv.wa", 32'(rf_wa), 3);
      step(1'b0);
      chk("ldw.after.rf_we", 32'(rf_we), 0);
      chk("ldw.after.fetch", 32'(imem_addr), 1);
      chk("ldw.after.retired", 32'(retired), 1);
      step(1'b0);
      step(1'b0);
      chk("halt.exec.halted", 32'(halted), 0);
      chk("halt.exec.retired", 32'(retired), 1);
      step(1'b0);
      chk("halt.halted", 32'(halted), 1);
      chk("halt.busy", 32'(busy), 0);
      chk("halt.retired", 32'(retired), 2);
      for (int k = 0; k < 4; k++) begin
         start = (k % 2 == 0);
         step(1'b0);
         chk("halt.hold.halted", 32'(halted), 1);
         chk("halt.hold.busy", 32'(busy), 0);
         chk("halt.hold.pc", 32'(imem_addr), 2);
         chk("halt.hold.retired", 32'(retired), 2);
      end

      // ---------------- illegal opcode ----------------
      clear_rom();
      rom[0] = 16'h9000;  // illegal
      rom[1] = 16'h1407;  // LDI R1,7
      rom[2] = 16'hF000;  // HALT
      do_reset();
      start = 1'b1;
      step(1'b0);
      step(1'b0);
      step(1'b0);
      chk("ill.exec.rf_we", 32'(rf_we), 0);
      chk("ill.exec.dmem_we", 32'(dmem_we), 0);
      chk("ill.exec.dmem_re", 32'(dmem_re), 0);
      chk("ill.exec.illegal", 32'(illegal), 0);
      step(1'b0);
      chk("ill.illegal", 32'(illegal), 1);
      chk("ill.fetch", 32'(imem_addr), 1);
      chk("ill.busy", 32'(busy), 1);
      chk("ill.halted", 32'(halted), 0);
      chk("ill_h.halted", 32'(h_halted), 1);
      chk("ill_h.illegal", 32'(h_illegal), 1);
      chk("ill_h.busy", 32'(h_busy), 0);
      chk("ill_h.retired", 32'(h_retired), 1);
      step(1'b0);
      step(1'b0);
      chk("ill.ldi.rf_we", 32'(rf_we), 1);
      chk("ill.ldi.imm", 32'(imm), 32'h07);
      chk("ill.ldi.wa", 32'(rf_wa), 1);
      for (int k = 0; k < 4; k++) step(1'b0);
      chk("ill.sticky", 32'(illegal), 1);
      chk("ill.end.halted", 32'(halted), 1);
      chk("ill.end.retired", 32'(retired), 3);

      // ---------------- reset during MEM ----------------
      clear_rom();
      rom[0] = 16'h1001;  // LDI R0,1
      rom[1] = 16'h5C20;  // LD R3 <- 0x20
      do_reset();
      start = 1'b1;
      for (int k = 0; k < 7; k++) step(1'b0);
      chk("rmem.pre.busy", 32'(busy), 1);
      chk("rmem.pre.retired", 32'(retired), 1);
      rst_n = 1'b0;
      #1;
      chk_reset_vals("rmem");

      // ---------------- reset during EXEC of ST ----------------
      clear_rom();
      rom[0] = 16'h1001;  // LDI R0,1
      rom[1] = 16'h6010;  // ST R0 -> 0x10
      do_reset();
      start = 1'b1;
      for (int k = 0; k < 6; k++) step(1'b0);
      chk("rst_st.pre.dmem_we", 32'(dmem_we), 1);
      rst_n = 1'b0;
      start = 1'b0;
      #1;
      chk_reset_vals("rst_st");
      step(1'b0);
      chk("rst_st.held.dmem_we", 32'(dmem_we), 0);
      rst_n = 1'b1;
      step(1'b0);
      chk("rst_st.idle.busy", 32'(busy), 0);
      chk("rst_st.idle.dmem_we", 32'(dmem_we), 0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
